// File: rtl/map_sel_pkg.sv
// -----------------------------------------------------------------------------
// map_sel_pkg
//   Shared types and sizing helpers for the mapper-select hub.
//   - state_e     : settle FSM states (HOLD while a new mapper settles, RUN once
//                   the selection is committed).
//   - sel_w()     : width of a slot number able to hold 0..n_slots, where the
//                   value n_slots means "nominal mapper".
//   - cnt_w()     : width of the settle counter for a given window length.
//   Also provides a fallback value for BW_MAP_OUT when the build has none.
// -----------------------------------------------------------------------------
`ifndef BW_MAP_OUT
`define BW_MAP_OUT 16
`endif

package map_sel_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int sel_w(input int n_slots);
    return $clog2(n_slots + 1);
  endfunction

  function automatic int cnt_w(input int settle_cyc);
    return $clog2(settle_cyc + 1);
  endfunction

endpackage

// File: rtl/map_sel_lookup.sv
// -----------------------------------------------------------------------------
// map_sel_lookup
//   Combinational priority matcher. Finds the lowest enabled slot whose mapper
//   number equals idx.
// Ports:
//   idx      in  IDX_W           mapper number to look up
//   slot_idx in  N_SLOTS*IDX_W   mapper number served by slot i at [i*IDX_W +: IDX_W]
//   slot_en  in  N_SLOTS         per-slot enable mask
//   slot     out SEL_W           lowest matching slot, or N_SLOTS if none
//   hit      out 1               a table slot matched
// -----------------------------------------------------------------------------
module map_sel_lookup
  import map_sel_pkg::*;
#(
  parameter int N_SLOTS = 32,
  parameter int IDX_W   = 8,
  parameter int SEL_W   = sel_w(N_SLOTS)
) (
  input  logic [IDX_W-1:0]         idx,
  input  logic [N_SLOTS*IDX_W-1:0] slot_idx,
  input  logic [N_SLOTS-1:0]       slot_en,
  output logic [SEL_W-1:0]         slot,
  output logic                     hit
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  // Scanning from the top down lets the lowest matching slot overwrite last,
  // which gives lowest-index priority without a priority-encoder chain by hand.
  always_comb begin
    slot = SEL_W'(N_SLOTS);
    hit  = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (slot_en[i] && (slot_idx[i*IDX_W +: IDX_W] == idx)) begin
        slot = SEL_W'(i);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_sel_hub.sv
// -----------------------------------------------------------------------------
// map_sel_hub
//   Registered mapper-select hub. Picks one of N_SLOTS mapper output buses, or
//   the nominal mapper, by matching the registered map index against a runtime
//   slot table. Every index change opens a settle window of SETTLE_CYC cycles
//   during which the safe idle word is driven, so a half-decoded mapper never
//   reaches the cart bus. SETTLE_CYC must be >= 1.
// Ports:
//   clk         in  1                  system clock
//   rst         in  1                  synchronous active-high reset
//   map_idx     in  IDX_W              requested mapper number
//   slot_idx    in  N_SLOTS*IDX_W      mapper number served by slot i
//   slot_en     in  N_SLOTS            per-slot enable mask
//   slot_out    in  N_SLOTS*OUT_W      flattened mapper outputs, slot i at [i*OUT_W +: OUT_W]
//   nom_out     in  OUT_W              nominal mapper output
//   safe_out    in  OUT_W              idle word driven while switching
//   map_out     out OUT_W              selected mapper output
//   active_slot out $clog2(N_SLOTS+1)  committed slot; N_SLOTS means nominal
//   hit         out 1                  committed selection is a table slot
//   switching   out 1                  settle window in progress
// -----------------------------------------------------------------------------
module map_sel_hub
  import map_sel_pkg::*;
#(
  parameter int N_SLOTS    = 32,
  parameter int IDX_W      = 8,
  parameter int OUT_W      = `BW_MAP_OUT,
  parameter int SETTLE_CYC = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             map_idx,
  input  logic [N_SLOTS*IDX_W-1:0]     slot_idx,
  input  logic [N_SLOTS-1:0]           slot_en,
  input  logic [N_SLOTS*OUT_W-1:0]     slot_out,
  input  logic [OUT_W-1:0]             nom_out,
  input  logic [OUT_W-1:0]             safe_out,
  output logic [OUT_W-1:0]             map_out,
  output logic [sel_w(N_SLOTS)-1:0]    active_slot,
  output logic                         hit,
  output logic                         switching
);

  localparam int SEL_W = sel_w(N_SLOTS);
  localparam int CNT_W = cnt_w(SETTLE_CYC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   active_slot_q, active_slot_d;
  logic               hit_q, hit_d;

  logic [SEL_W-1:0]   lk_slot;
  logic               lk_hit;

  // Lookup runs on the registered index so the table is only consulted for a
  // value that has been stable through the whole window.
  map_sel_lookup #(
    .N_SLOTS (N_SLOTS),
    .IDX_W   (IDX_W),
    .SEL_W   (SEL_W)
  ) u_lookup (
    .idx      (idx_q),
    .slot_idx (slot_idx),
    .slot_en  (slot_en),
    .slot     (lk_slot),
    .hit      (lk_hit)
  );

  // Next-state logic. An index change always wins over a pending commit, so
  // the window restarts instead of committing a stale selection.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    active_slot_d = active_slot_q;
    hit_d         = hit_q;

    unique case (state_q)
      RUN: begin
        if (map_idx != idx_q) begin
          idx_d   = map_idx;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (map_idx != idx_q) begin
          idx_d = map_idx;
          cnt_d = '0;
        end else begin
          // Never wraps: the commit below leaves HOLD before cnt can exceed
          // SETTLE_CYC, which the counter width can represent.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            active_slot_d = lk_slot;
            hit_d         = lk_hit;
            state_d       = RUN;
          end
        end
      end

      default: state_d = HOLD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_slot_q <= SEL_W'(N_SLOTS);
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_slot_q <= active_slot_d;
      hit_q         <= hit_d;
    end
  end

  // Data path is purely combinational from the registered select, so slot and
  // nominal outputs reach map_out with zero added latency while in RUN.
  always_comb begin
    map_out = safe_out;
    if (state_q == RUN) begin
      map_out = nom_out;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (active_slot_q == SEL_W'(i)) begin
          map_out = slot_out[i*OUT_W +: OUT_W];
        end
      end
    end
  end

  assign active_slot = active_slot_q;
  assign hit         = hit_q;
  assign switching   = (state_q == HOLD);

endmodule

// File: tb/tb_map_sel_hub.sv
module tb_map_sel_hub;

  localparam int N_SLOTS    = 4;
  localparam int IDX_W      = 8;
  localparam int OUT_W      = 16;
  localparam int SETTLE_CYC = 8;

  logic                     clk;
  logic                     rst;
  logic [IDX_W-1:0]         map_idx;
  logic [N_SLOTS*IDX_W-1:0] slot_idx;
  logic [N_SLOTS-1:0]       slot_en;
  logic [N_SLOTS*OUT_W-1:0] slot_out;
  logic [OUT_W-1:0]         nom_out;
  logic [OUT_W-1:0]         safe_out;
  logic [OUT_W-1:0]         map_out;
  logic [2:0]               active_slot;
  logic                     hit;
  logic                     switching;

  int n_vec;
  int n_err;

  map_sel_hub #(
    .N_SLOTS    (N_SLOTS),
    .IDX_W      (IDX_W),
    .OUT_W      (OUT_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .map_idx     (map_idx),
    .slot_idx    (slot_idx),
    .slot_en     (slot_en),
    .slot_out    (slot_out),
    .nom_out     (nom_out),
    .safe_out    (safe_out),
    .map_out     (map_out),
    .active_slot (active_slot),
    .hit         (hit),
    .switching   (switching)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs have just been changed in RUN: expect 8 safe cycles holding the old
  // selection, then a commit to the expected slot on the 9th edge.
  task automatic settle_and_commit(input string name, input logic [2:0] prev_slot,
                                   input logic prev_hit, input logic [2:0] exp_slot,
                                   input logic [15:0] exp_out, input logic exp_hit);
    for (int k = 0; k < SETTLE_CYC; k++) begin
      tick();
      n_vec++;
      if (switching !== 1'b1 || map_out !== 16'h0000 ||
          active_slot !== prev_slot || hit !== prev_hit) begin
        n_err++;
        $display("FAIL %s window cyc %0d: sw=%b out=%h slot=%0d hit=%b, want sw=1 out=0000 slot=%0d hit=%b",
                 name, k, switching, map_out, active_slot, hit, prev_slot, prev_hit);
      end
    end
    tick();
    n_vec++;
    if (switching !== 1'b0 || map_out !== exp_out ||
        active_slot !== exp_slot || hit !== exp_hit) begin
      n_err++;
      $display("FAIL %s commit: sw=%b out=%h slot=%0d hit=%b, want sw=0 out=%h slot=%0d hit=%b",
               name, switching, map_out, active_slot, hit, exp_out, exp_slot, exp_hit);
    end
  endtask

  // Called right after the last edge with rst high: the reset state must hold
  // for the full window, then commit the nominal mapper for map_idx=0.
  task automatic reset_window(input string name);
    for (int k = 0; k < SETTLE_CYC; k++) begin
      n_vec++;
      if (switching !== 1'b1 || map_out !== 16'h0000 || active_slot !== 3'd4 || hit !== 1'b0) begin
        n_err++;
        $display("FAIL %s window cyc %0d: sw=%b out=%h slot=%0d hit=%b, want sw=1 out=0000 slot=4 hit=0",
                 name, k, switching, map_out, active_slot, hit);
      end
      tick();
    end
    n_vec++;
    if (switching !== 1'b0 || map_out !== 16'h5555 || active_slot !== 3'd4 || hit !== 1'b0) begin
      n_err++;
      $display("FAIL %s commit: sw=%b out=%h slot=%0d hit=%b, want sw=0 out=5555 slot=4 hit=0",
               name, switching, map_out, active_slot, hit);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    map_idx = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    reset_window("reset");
  endtask

  task automatic test_step();
    map_idx = 8'd15;
    settle_and_commit("step15", 3'd4, 1'b0, 3'd0, 16'hA000, 1'b1);
  endtask

  task automatic test_restart();
    map_idx = 8'd0;
    settle_and_commit("to_nominal", 3'd0, 1'b1, 3'd4, 16'h5555, 1'b0);
    map_idx = 8'd15;
    // Six edges reach HOLD cycle 5 (cnt 0..5).
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (switching !== 1'b1 || active_slot !== 3'd4) begin
        n_err++;
        $display("FAIL restart_pre cyc %0d: sw=%b slot=%0d, want sw=1 slot=4", k, switching, active_slot);
      end
    end
    map_idx = 8'd42;
    settle_and_commit("restart42", 3'd4, 1'b0, 3'd2, 16'hA002, 1'b1);
  endtask

  task automatic test_slot_en();
    slot_en = 4'b1110;
    map_idx = 8'd15;
    settle_and_commit("en_skip0", 3'd2, 1'b1, 3'd1, 16'hA001, 1'b1);
    slot_en = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (active_slot !== 3'd1 || map_out !== 16'hA001 || hit !== 1'b1 || switching !== 1'b0) begin
        n_err++;
        $display("FAIL en_noreselect cyc %0d: slot=%0d out=%h hit=%b sw=%b, want slot=1 out=A001 hit=1 sw=0",
                 k, active_slot, map_out, hit, switching);
      end
    end
    map_idx = 8'd0;
    settle_and_commit("en_off_to0", 3'd1, 1'b1, 3'd4, 16'h5555, 1'b0);
    map_idx = 8'd15;
    settle_and_commit("en_off_to15", 3'd4, 1'b0, 3'd4, 16'h5555, 1'b0);
    slot_en = 4'b1111;
  endtask

  task automatic test_table_change();
    map_idx = 8'd42;
    settle_and_commit("tbl_to42", 3'd4, 1'b0, 3'd2, 16'hA002, 1'b1);
    slot_idx[3*IDX_W +: IDX_W] = 8'd99;
    tick();
    tick();
    n_vec++;
    if (active_slot !== 3'd2 || map_out !== 16'hA002 || switching !== 1'b0) begin
      n_err++;
      $display("FAIL tbl_noreselect: slot=%0d out=%h sw=%b, want slot=2 out=A002 sw=0",
               active_slot, map_out, switching);
    end
    map_idx = 8'd99;
    settle_and_commit("tbl_to99", 3'd2, 1'b1, 3'd3, 16'hA003, 1'b1);
  endtask

  task automatic test_latency();
    slot_out[3*OUT_W +: OUT_W] = 16'hBEEF;
    #1;
    n_vec++;
    if (map_out !== 16'hBEEF) begin
      n_err++;
      $display("FAIL latency_slot: out=%h, want BEEF", map_out);
    end
    slot_out[3*OUT_W +: OUT_W] = 16'hA003;
    #1;
    n_vec++;
    if (map_out !== 16'hA003) begin
      n_err++;
      $display("FAIL latency_restore: out=%h, want A003", map_out);
    end
  endtask

  task automatic test_reset_mid_hold();
    map_idx = 8'd15;
    // Capture edge plus three more: HOLD cycle 3.
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if (switching !== 1'b1 || active_slot !== 3'd3) begin
      n_err++;
      $display("FAIL midhold_pre: sw=%b slot=%0d, want sw=1 slot=3", switching, active_slot);
    end
    rst     = 1'b1;
    map_idx = 8'd0;
    tick();
    rst = 1'b0;
    reset_window("midhold_reset");
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    map_idx  = 8'd0;
    slot_idx = {8'd246, 8'd42, 8'd15, 8'd15};
    slot_en  = 4'b1111;
    slot_out = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    nom_out  = 16'h5555;
    safe_out = 16'h0000;

    test_reset();
    test_step();
    test_restart();
    test_slot_en();
    test_table_change();
    test_latency();
    test_reset_mid_hold();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/map_sel_hub.md
Name: map_sel_hub

Overview:
- Parametrised, registered successor to the combinational mapper-select hub.
- Selects one of N_SLOTS mapper output buses, or the nominal mapper, by matching map_idx against a runtime slot table.
- Every mapper change passes through a settle window. During that window map_out is forced to a safe idle word, so a half-decoded mapper never drives the cart bus.
- Sits between the per-mapper instances and the cart pin logic.

Parameters:
- N_SLOTS, 32, number of selectable mapper slots (excluding nominal).
- IDX_W, 8, mapper index width.
- OUT_W, `BW_MAP_OUT, width of one mapper output bus.
- SETTLE_CYC, 8, consecutive cycles map_idx must be stable before commit; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- map_idx  in  IDX_W  requested mapper number.
- slot_idx  in  N_SLOTS*IDX_W  mapper number served by slot i, at bits [i*IDX_W +: IDX_W].
- slot_en  in  N_SLOTS  per-slot enable mask.
- slot_out  in  N_SLOTS*OUT_W  flattened mapper outputs, slot i at [i*OUT_W +: OUT_W].
- nom_out  in  OUT_W  nominal mapper output.
- safe_out  in  OUT_W  idle word driven while switching.
- map_out  out  OUT_W  selected mapper output.
- active_slot  out  $clog2(N_SLOTS+1)  committed slot; the value N_SLOTS means nominal.
- hit  out  1  committed selection is a table slot, not nominal.
- switching  out  1  settle window in progress.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=HOLD, cnt=0, idx_q=0, active_slot=N_SLOTS, hit=0, switching=1. map_out follows safe_out.
- Lookup (combinational):
  - match[i] = slot_en[i] && slot_idx[i]==idx_q.
  - The lowest matching i wins.
  - No match gives N_SLOTS (nominal).
- State RUN:
  - switching=0.
  - map_out = slot_out[active_slot], or nom_out when active_slot==N_SLOTS.
  - Data path is combinational from the registered select: zero-cycle latency from slot_out/nom_out to map_out.
  - If map_idx != idx_q: capture idx_q<=map_idx, cnt<=0, go to HOLD. map_out becomes safe_out from the next cycle.
- State HOLD:
  - switching=1 and map_out=safe_out.
  - If map_idx != idx_q: idx_q<=map_idx, cnt<=0. The window restarts.
  - Otherwise cnt<=cnt+1.
  - When cnt==SETTLE_CYC-1 and map_idx==idx_q: active_slot<=lookup result, hit<=(result!=N_SLOTS), go to RUN.
  - Total time in HOLD after the last change is exactly SETTLE_CYC cycles.
- Table changes: slot_idx and slot_en changes during RUN do not re-select. A re-select happens only after a map_idx change or a reset.
- Outputs: active_slot and hit change only on commit or reset.
- Counter width: $clog2(SETTLE_CYC+1). The counter never wraps; it saturates by design because commit exits HOLD.
- Reset mid-HOLD: returns to the reset state with the same settle sequence and idx_q=0.
- Simultaneous commit and map_idx change: the change wins, the window restarts, and there is no commit.

Decomposition:
- Shared package map_sel_pkg: state enum (HOLD, RUN) and a function for active_slot width.
- One sub-module, map_sel_lookup: combinational priority matcher (idx, slot_idx, slot_en -> slot number and hit).

Test Plan:
All scenarios use N_SLOTS=4, IDX_W=8, OUT_W=16, SETTLE_CYC=8, slot_idx={246,42,15,15}, slot_en=4'b1111, slot_out[i]=16'hA000+i, nom_out=16'h5555, safe_out=16'h0000.
- Reset, map_idx=0: switching=1 and map_out=0000 for 8 cycles after reset release, then map_out=5555, active_slot=4, hit=0.
- Step map_idx to 15 while in RUN: next cycle map_out=0000. After 8 stable cycles active_slot=0 (lowest of the duplicate slots 0 and 1), map_out=A000, hit=1.
- map_idx 15 then 42, with the change on HOLD cycle 5: window restarts. Commit occurs 8 cycles after the 42 edge, giving active_slot=2 and map_out=A002. No commit to slot 0 occurs.
- Clear slot_en[0] and step to 15: commit to slot 1, map_out=A001. With slot_en=0, stepping to 15 commits nominal: map_out=5555, hit=0.
- Change slot_idx[3] 246 to 99 while in RUN: no change to active_slot. Then step map_idx to 99: commit to slot 3, map_out=A003.
- Assert rst on HOLD cycle 3: next cycle active_slot=4, hit=0, switching=1, map_out=0000. Full 8-cycle window repeats.
